dmem_arbiter: RTL and testbench

Controller and arbiter for the single-ported data memory behind the MEM stage. It lets two requesters share the memory: the pipeline's MEM stage and a secondary master (DMA or debug loader). It sequences each access over a configurable multi-cycle memory latency and stalls the pipeline until its access completes. It sits between the MEM-stage control/ALU outputs and the DataMemory instance, and drives DataMemory's write enable, read enable, address and write data.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (p_*) and a secondary master (d_*). Each access runs for
// MEM_LATENCY cycles. The pipeline is stalled until its own access completes.
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate and latch the winner's request
//   ACCESS | strobes asserted, latency counter running down to zero
//   RESP   | done pulse to the granted requester; always back to IDLE
module dmem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             p_req_i,
  input  logic             p_we_i,
  input  logic [WIDTH-1:0] p_addr_i,
  input  logic [WIDTH-1:0] p_wdata_i,
  output logic [WIDTH-1:0] p_rdata_o,
  output logic             p_done_o,
  output logic             stall_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [WIDTH-1:0] d_addr_i,
  input  logic [WIDTH-1:0] d_wdata_i,
  output logic [WIDTH-1:0] d_rdata_o,
  output logic             d_done_o,
  output logic             mem_we_o,
  output logic             mem_re_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t           state_q;
  logic [2:0]       lat_q;
  logic [3:0]       starve_q;
  logic             gnt_sec_q;
  logic             mem_we_q;
  logic             mem_re_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [WIDTH-1:0] p_rdata_q;
  logic [WIDTH-1:0] d_rdata_q;
  logic             p_done_q;
  logic             d_done_q;

  logic             sec_win_d;
  logic             win_we_d;
  logic [WIDTH-1:0] win_addr_d;
  logic [WIDTH-1:0] win_wdata_d;

  // Arbitration: the pipeline wins ties unless the secondary has lost STARVE_LIMIT times in a row.
  always_comb begin
    sec_win_d   = d_req_i & (~p_req_i | (starve_q == STARVE_MAX));
    win_we_d    = sec_win_d ? d_we_i    : p_we_i;
    win_addr_d  = sec_win_d ? d_addr_i  : p_addr_i;
    win_wdata_d = sec_win_d ? d_wdata_i : p_wdata_i;
  end

  // Access sequencer: latch grant, run the latency counter, capture read data, pulse done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      gnt_sec_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      p_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      p_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (p_req_i | d_req_i) begin
            gnt_sec_q   <= sec_win_d;
            mem_we_q    <= win_we_d;
            mem_re_q    <= ~win_we_d;
            mem_addr_q  <= win_addr_d;
            mem_wdata_q <= win_wdata_d;
            lat_q       <= LAT_INIT;
            state_q     <= S_ACCESS;
          end
          // Starvation only accumulates while the secondary is actually waiting.
          if (!d_req_i || sec_win_d) begin
            starve_q <= '0;
          end else if (p_req_i && (starve_q < STARVE_MAX)) begin
            starve_q <= starve_q + 4'd1;
          end
        end
        S_ACCESS: begin
          if (lat_q == 3'd0) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            if (mem_re_q) begin
              if (gnt_sec_q) d_rdata_q <= mem_rdata_i;
              else           p_rdata_q <= mem_rdata_i;
            end
            if (gnt_sec_q) d_done_q <= 1'b1;
            else           p_done_q <= 1'b1;
            state_q <= S_RESP;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o     = p_req_i & ~p_done_q;
  assign p_done_o    = p_done_q;
  assign d_done_o    = d_done_q;
  assign p_rdata_o   = p_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: a main instance (latency 2) plus
// latency-1 and latency-7 instances sharing the pipeline-side stimulus.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        p_done, d_done, stall, mem_we, mem_re;

  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  logic [31:0] a1_p_rdata, a1_d_rdata, a1_mem_addr, a1_mem_wdata, a1_mem_rdata;
  logic        a1_p_done, a1_d_done, a1_stall, a1_mem_we, a1_mem_re;
  logic [31:0] a7_p_rdata, a7_d_rdata, a7_mem_addr, a7_mem_wdata, a7_mem_rdata;
  logic        a7_p_done, a7_d_done, a7_stall, a7_mem_we, a7_mem_re;

  logic [31:0] mem [0:255];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_rdata_o(p_rdata), .p_done_o(p_done), .stall_o(stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_done_o(d_done),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .p_req_i(p_req), .p_we_i(zero1), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_rdata_o(a1_p_rdata), .p_done_o(a1_p_done), .stall_o(a1_stall),
    .d_req_i(zero1), .d_we_i(zero1), .d_addr_i(zero32), .d_wdata_i(zero32),
    .d_rdata_o(a1_d_rdata), .d_done_o(a1_d_done),
    .mem_we_o(a1_mem_we), .mem_re_o(a1_mem_re), .mem_addr_o(a1_mem_addr),
    .mem_wdata_o(a1_mem_wdata), .mem_rdata_i(a1_mem_rdata)
  );

  dmem_arbiter #(.WIDTH(32), .MEM_LATENCY(7), .STARVE_LIMIT(4)) dut_l7 (
    .clk_i(clk), .rst_i(rst),
    .p_req_i(p_req), .p_we_i(zero1), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_rdata_o(a7_p_rdata), .p_done_o(a7_p_done), .stall_o(a7_stall),
    .d_req_i(zero1), .d_we_i(zero1), .d_addr_i(zero32), .d_wdata_i(zero32),
    .d_rdata_o(a7_d_rdata), .d_done_o(a7_d_done),
    .mem_we_o(a7_mem_we), .mem_re_o(a7_mem_re), .mem_addr_o(a7_mem_addr),
    .mem_wdata_o(a7_mem_wdata), .mem_rdata_i(a7_mem_rdata)
  );

  // Memory model: combinational read, writes land on the clock edge (main instance only).
  assign mem_rdata    = mem[mem_addr[7:0]];
  assign a1_mem_rdata = mem[a1_mem_addr[7:0]];
  assign a7_mem_rdata = mem[a7_mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  int   ndone;
  logic order [0:15];
  int   done1, done7, donem, str1, str7;
  logic [31:0] rd1, rd7;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    rst = 1'b1;
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h10; p_wdata = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0;

    // Reset held three cycles with both requests high
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_p_done", {31'b0, p_done}, 32'd0);
      chk("rst_d_done", {31'b0, d_done}, 32'd0);
      chk("rst_p_rdata", p_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'd1);
    end

    // Release: pipeline read of 0x10 wins the tie in cycle 0
    cyc(); rst = 1'b0; #1;
    chk("rd_c0_stall", {31'b0, stall}, 32'd1);
    cyc(); d_req = 1'b0; #1;
    chk("rd_c1_re", {31'b0, mem_re}, 32'd1);
    chk("rd_c1_we", {31'b0, mem_we}, 32'd0);
    chk("rd_c1_addr", mem_addr, 32'h10);
    chk("rd_c1_stall", {31'b0, stall}, 32'd1);
    cyc(); #1;
    chk("rd_c2_re", {31'b0, mem_re}, 32'd1);
    chk("rd_c2_addr", mem_addr, 32'h10);
    chk("rd_c2_stall", {31'b0, stall}, 32'd1);
    chk("rd_c2_done", {31'b0, p_done}, 32'd0);
    cyc(); #1;
    chk("rd_c3_done", {31'b0, p_done}, 32'd1);
    chk("rd_c3_rdata", p_rdata, 32'hDEADBEEF);
    chk("rd_c3_stall", {31'b0, stall}, 32'd0);
    chk("rd_c3_re", {31'b0, mem_re}, 32'd0);
    chk("rd_c3_d_done", {31'b0, d_done}, 32'd0);
    p_req = 1'b0;
    cyc(); #1;
    chk("idle_re", {31'b0, mem_re}, 32'd0);
    chk("idle_done", {31'b0, p_done}, 32'd0);

    // Secondary write 0x12345678 -> 0x20
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; #1;
    chk("wr_c0_stall", {31'b0, stall}, 32'd0);
    cyc(); #1;
    chk("wr_c1_we", {31'b0, mem_we}, 32'd1);
    chk("wr_c1_re", {31'b0, mem_re}, 32'd0);
    chk("wr_c1_addr", mem_addr, 32'h20);
    chk("wr_c1_wdata", mem_wdata, 32'h12345678);
    cyc(); #1;
    chk("wr_c2_we", {31'b0, mem_we}, 32'd1);
    cyc(); #1;
    chk("wr_c3_d_done", {31'b0, d_done}, 32'd1);
    chk("wr_c3_we", {31'b0, mem_we}, 32'd0);
    chk("wr_c3_d_rdata", d_rdata, 32'h0);
    chk("wr_c3_p_rdata", p_rdata, 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;

    // Pipeline reads back 0x20
    cyc(); p_req = 1'b1; p_addr = 32'h20; #1;
    chk("rb_c0_stall", {31'b0, stall}, 32'd1);
    cyc(); #1;
    chk("rb_c1_addr", mem_addr, 32'h20);
    cyc(); #1;
    chk("rb_c2_stall", {31'b0, stall}, 32'd1);
    cyc(); #1;
    chk("rb_c3_done", {31'b0, p_done}, 32'd1);
    chk("rb_c3_rdata", p_rdata, 32'h12345678);
    chk("rb_c3_d_rdata", d_rdata, 32'h0);
    p_req = 1'b0;
    cyc(); #1;

    // Contention: both requesters held high for ten grants
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (i == 0) begin
        p_req = 1'b1; p_addr = 32'h10;
        d_req = 1'b1; d_addr = 32'h20;
      end
      #1;
      if (p_done && ndone < 16) begin order[ndone] = 1'b0; ndone++; end
      if (d_done && ndone < 16) begin order[ndone] = 1'b1; ndone++; end
      if (!p_done) chk("ct_stall", {31'b0, stall}, 32'd1);
    end
    p_req = 1'b0; d_req = 1'b0;
    chk("ct_ndone", 32'(ndone), 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("ct_grant%0d", k), {31'b0, order[k]}, (k % 5 == 4) ? 32'd1 : 32'd0);
    chk("ct_p_rdata", p_rdata, 32'hDEADBEEF);
    chk("ct_d_rdata", d_rdata, 32'h12345678);

    // Reset in the second ACCESS cycle of a pipeline read
    cyc(); #1;
    chk("ra_idle_re", {31'b0, mem_re}, 32'd0);
    cyc(); p_req = 1'b1; p_addr = 32'h10; #1;
    cyc(); #1;
    chk("ra_c1_re", {31'b0, mem_re}, 32'd1);
    cyc(); rst = 1'b1; #1;
    chk("ra_rst_re", {31'b0, mem_re}, 32'd0);
    chk("ra_rst_done", {31'b0, p_done}, 32'd0);
    chk("ra_rst_stall", {31'b0, stall}, 32'd1);
    cyc(); #1;
    chk("ra_rst2_done", {31'b0, p_done}, 32'd0);
    chk("ra_rst2_rdata", p_rdata, 32'h0);
    cyc(); rst = 1'b0; #1;
    chk("ra_c0_done", {31'b0, p_done}, 32'd0);
    cyc(); #1;
    chk("ra_c1b_re", {31'b0, mem_re}, 32'd1);
    cyc(); #1;
    chk("ra_c2b_done", {31'b0, p_done}, 32'd0);
    cyc(); #1;
    chk("ra_c3_done", {31'b0, p_done}, 32'd1);
    chk("ra_c3_rdata", p_rdata, 32'hDEADBEEF);
    p_req = 1'b0;

    // Latency 1 / 2 / 7 side by side
    repeat (12) cyc();
    #1;
    chk("lat_idle_re1", {31'b0, a1_mem_re}, 32'd0);
    chk("lat_idle_re7", {31'b0, a7_mem_re}, 32'd0);
    done1 = -1; done7 = -1; donem = -1; str1 = 0; str7 = 0; rd1 = '0; rd7 = '0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (c == 0) begin p_req = 1'b1; p_addr = 32'h10; end
      #1;
      if (done1 < 0) begin
        if (a1_mem_re) str1++;
        if (a1_p_done) begin done1 = c; rd1 = a1_p_rdata; end
      end
      if (done7 < 0) begin
        if (a7_mem_re) str7++;
        if (a7_p_done) begin done7 = c; rd7 = a7_p_rdata; end
      end
      if (donem < 0 && p_done) donem = c;
    end
    p_req = 1'b0;
    chk("lat1_done_cycle", 32'(done1), 32'd2);
    chk("lat1_strobes", 32'(str1), 32'd1);
    chk("lat1_rdata", rd1, 32'hDEADBEEF);
    chk("lat7_done_cycle", 32'(done7), 32'd8);
    chk("lat7_strobes", 32'(str7), 32'd7);
    chk("lat7_rdata", rd7, 32'hDEADBEEF);
    chk("lat2_done_cycle", 32'(donem), 32'd3);

    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
